cpu_axi_master: RTL

CPU_AXI_MASTER -- requirements
Module: cpu_axi_master

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_master_p.sv | 55 +++++
 rtl/axi_beat_cnt.sv | 31 +++
 rtl/cpu_axi_master.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 widths, encodings and the CPU-to-AXI bridge state type.
package axi_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_LEN_W  = 8;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WREQ,
    ST_WRESP
  } cpu_axi_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/axi_master_p.sv
// AXI4 channel bundle; master drives AW/W/AR payloads and B/R readies.
interface AXI_master_p;
  import axi_pkg::*;

  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [AXI_LEN_W-1:0]  awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [AXI_ID_W-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [AXI_LEN_W-1:0]  arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi_beat_cnt.sv
// Read beat counter; flags the expected last beat and any beat at or past it.
module axi_beat_cnt #(
  parameter int unsigned CNT_W = 5,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_last,
  output logic             o_past
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_len_ext;

  assign w_len_ext = {{(CNT_W-LEN_W){1'b0}}, i_len};
  assign o_last    = (r_cnt == w_len_ext);
  assign o_past    = (r_cnt >= w_len_ext);

  // Saturates so a runaway slave burst keeps reporting overrun.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_axi_master.sv
// Single-outstanding CPU request to AXI4 bridge: single-beat writes, INCR read bursts.
module cpu_axi_master
  import axi_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'h0,
  parameter logic [3:0] MAX_LEN   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [3:0]  core_len,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_done,
  output logic        core_err,
  AXI_master_p.master master
);

  cpu_axi_state_t r_state, w_state_nx;

  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_rerr;

  logic w_gnt, w_done, w_cnt_inc, w_cnt_clr;
  logic w_last, w_past;
  logic w_beat_err, w_berr;
  logic w_aw_hs, w_w_hs;

  axi_beat_cnt #(.CNT_W(5), .LEN_W(4)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_inc (w_cnt_inc),
    .i_len (r_len),
    .o_last(w_last),
    .o_past(w_past)
  );

  assign w_aw_hs = master.awvalid & master.awready;
  assign w_w_hs  = master.wvalid & master.wready;

  assign w_beat_err = (master.rresp != AXI_RESP_OKAY) | (master.rid != MASTER_ID) |
                      (master.rlast ? ~w_last : w_past);
  assign w_berr     = (master.bresp != AXI_RESP_OKAY) | (master.bid != MASTER_ID);

  always_comb begin
    w_state_nx = r_state;
    w_gnt      = 1'b0;
    w_done     = 1'b0;
    w_cnt_inc  = 1'b0;
    w_cnt_clr  = 1'b0;
    case (r_state)
      ST_IDLE: if (core_req) begin
        w_gnt      = 1'b1;
        w_cnt_clr  = 1'b1;
        w_state_nx = core_we ? ST_WREQ : ST_RADDR;
      end
      ST_RADDR: if (master.arready) w_state_nx = ST_RDATA;
      ST_RDATA: if (master.rvalid) begin
        w_cnt_inc = 1'b1;
        if (master.rlast) begin
          w_done     = 1'b1;
          w_cnt_clr  = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      ST_WREQ: if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_nx = ST_WRESP;
      ST_WRESP: if (master.bvalid) begin
        w_done     = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_we      <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rerr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_gnt) begin
        r_addr    <= core_addr;
        r_len     <= clamp_len(core_len, MAX_LEN);
        r_wdata   <= core_wdata;
        r_wstrb   <= core_wstrb;
        r_we      <= core_we;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_rerr    <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
        // Read errors accumulate across the burst and surface only at RLAST.
        if (w_cnt_inc && w_beat_err) r_rerr <= 1'b1;
      end
    end
  end

  assign core_gnt    = w_gnt & ~rst;
  assign core_rvalid = w_cnt_inc & ~rst;
  assign core_rdata  = master.rdata;
  assign core_done   = w_done & ~rst;
  assign core_err    = core_done & (r_we ? w_berr : (r_rerr | w_beat_err));

  assign master.arvalid = (r_state == ST_RADDR);
  assign master.arid    = MASTER_ID;
  assign master.araddr  = r_addr;
  assign master.arlen   = {4'b0000, r_len};
  assign master.arsize  = AXI_SIZE_4B;
  assign master.arburst = AXI_BURST_INCR;
  assign master.rready  = (r_state == ST_RDATA);

  assign master.awvalid = (r_state == ST_WREQ) & ~r_aw_done;
  assign master.awid    = MASTER_ID;
  assign master.awaddr  = r_addr;
  assign master.awlen   = '0;
  assign master.awsize  = AXI_SIZE_4B;
  assign master.awburst = AXI_BURST_INCR;
  assign master.wvalid  = (r_state == ST_WREQ) & ~r_w_done;
  assign master.wdata   = r_wdata;
  assign master.wstrb   = r_wstrb;
  assign master.wlast   = 1'b1;
  assign master.bready  = (r_state == ST_WRESP);

endmodule
